// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and types for the matrix-multiplier datapath and its result drain.
//   LANES/ACC_W/Q_W/DEPTH : lane count, accumulator width, requantised width, buffered vectors
//   lane_idx_t, acc_t, q_t : lane index, signed accumulator, signed requantised value
//   cfg_t                  : per-vector output configuration {quant_en, relu, shift}
package matmul_pkg;
   localparam int LANES = 8;
   localparam int ACC_W = 32;
   localparam int Q_W   = 8;
   localparam int DEPTH = 2;
   typedef logic [2:0] lane_idx_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [Q_W-1:0] q_t;
   typedef struct packed {
      logic       quant_en;
      logic       relu;
      logic [4:0] shift;
   } cfg_t;
   typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/requant_lane.sv
// requant_lane: combinational ReLU, rounding right-shift and signed saturation for one lane.
//   x_i        : signed accumulator lane
//   quant_en_i : 1 = requantise, 0 = pass (post-ReLU) accumulator
//   relu_i     : clamp negative input to zero first
//   shift_i    : arithmetic right-shift amount with round-half-up
//   y_o        : result, sign-extended to ACC_W when requantised
module requant_lane
   import matmul_pkg::*;
(
   input  logic [ACC_W-1:0] x_i,
   input  logic             quant_en_i,
   input  logic             relu_i,
   input  logic [4:0]       shift_i,
   output logic [ACC_W-1:0] y_o
);
   localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(2**(Q_W-1) - 1);
   localparam logic signed [ACC_W:0] Q_MIN = -(ACC_W+1)'(2**(Q_W-1));
   acc_t xr;
   logic signed [ACC_W:0] rnd, sum, shr, sat;
   always_comb begin
      xr  = (relu_i && x_i[ACC_W-1]) ? '0 : x_i;
      rnd = (shift_i == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift_i - 5'd1));
      // one extra bit keeps the rounding add from wrapping near the positive limit
      sum = {xr[ACC_W-1], xr} + rnd;
      shr = sum >>> shift_i;
      sat = (shr > Q_MAX) ? Q_MAX : (shr < Q_MIN) ? Q_MIN : shr;
      // sat fits in Q_W signed bits, so truncation here is a sign-extension
      y_o = quant_en_i ? sat[ACC_W-1:0] : xr;
   end
endmodule

// File: rtl/matmul_result_drain.sv
// matmul_result_drain: ping-pong buffers multiplier result vectors and streams them one lane per beat.
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   done_i, matmul_i       : result-vector pulse and data from the multiplier
//   quant_en_i/relu_i/shift_i : output config, latched per captured vector
//   m_valid_o/m_ready_i    : beat handshake; m_data_o, m_idx_o, m_last_o carry the beat
//   busy_o                 : buffer non-empty
//   overflow_o, clr_ovf_i  : sticky dropped-vector flag and its synchronous clear
module matmul_result_drain
   import matmul_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   done_i,
   input  logic [LANES*ACC_W-1:0] matmul_i,
   input  logic                   quant_en_i,
   input  logic                   relu_i,
   input  logic [4:0]             shift_i,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic [ACC_W-1:0]       m_data_o,
   output logic [2:0]             m_idx_o,
   output logic                   m_last_o,
   output logic                   busy_o,
   output logic                   overflow_o,
   input  logic                   clr_ovf_i
);
   state_t state_q, state_d;
   logic [LANES*ACC_W-1:0] buf_q [DEPTH];
   logic [LANES*ACC_W-1:0] buf_d [DEPTH];
   cfg_t cfg_q [DEPTH];
   cfg_t cfg_d [DEPTH];
   logic wr_q, wr_d, rd_q, rd_d, ovf_q, ovf_d;
   logic [1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] data_q, data_d;
   lane_idx_t idx_q, idx_d;
   logic last_q, last_d;
   logic xfer, fin, cap, ld, bypass;
   lane_idx_t sel_lane;
   logic [ACC_W-1:0] sel_x, rq_y;
   cfg_t sel_cfg;

   always_comb begin
      xfer  = m_valid_o && m_ready_i;
      fin   = xfer && (idx_q == lane_idx_t'(LANES-1));
      // a final-lane transfer frees its slot in the same cycle, so a full buffer can still capture
      cap   = done_i && (cnt_q != 2'(DEPTH) || fin);
      cnt_d = cnt_q + 2'(cap) - 2'(fin);
      wr_d  = wr_q ^ cap;
      rd_d  = rd_q ^ fin;
      ovf_d = (done_i && !cap) || (ovf_q && !clr_ovf_i);
      buf_d = buf_q;
      cfg_d = cfg_q;
      if (cap) begin
         buf_d[wr_q] = matmul_i;
         cfg_d[wr_q] = '{quant_en_i, relu_i, shift_i};
      end
      // the output register reloads whenever it is empty or its beat is being taken
      ld       = !m_valid_o || m_ready_i;
      // nothing else buffered: the next beat is lane 0 of the vector arriving now
      bypass   = (cnt_q - 2'(fin)) == 2'd0;
      sel_lane = (m_valid_o && !fin) ? idx_q + 3'd1 : '0;
      sel_x    = bypass ? matmul_i[ACC_W-1:0] : buf_q[rd_d][sel_lane*ACC_W +: ACC_W];
      sel_cfg  = bypass ? cfg_t'{quant_en_i, relu_i, shift_i} : cfg_q[rd_d];
      data_d   = !ld ? data_q : (cnt_d != 2'd0) ? rq_y : '0;
      idx_d    = !ld ? idx_q : (cnt_d != 2'd0) ? sel_lane : '0;
      last_d   = !ld ? last_q : (cnt_d != 2'd0) && (sel_lane == lane_idx_t'(LANES-1));
   end

   requant_lane u_rq (
      .x_i        (sel_x),
      .quant_en_i (sel_cfg.quant_en),
      .relu_i     (sel_cfg.relu),
      .shift_i    (sel_cfg.shift),
      .y_o        (rq_y)
   );

   always_comb state_d = (cnt_d != 2'd0) ? STREAM : IDLE;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   // storage needs no reset: an empty count makes its contents unobservable
   always_ff @(posedge clk_i) begin
      buf_q <= buf_d;
      cfg_q <= cfg_d;
   end

   always_comb begin
      m_valid_o  = state_q == STREAM;
      m_data_o   = data_q;
      m_idx_o    = idx_q;
      m_last_o   = last_q;
      busy_o     = cnt_q != 2'd0;
      overflow_o = ovf_q;
   end
endmodule

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
- Sits directly downstream of the matrix-multiplier top; consumes its done_o pulse and 256-bit matmul_o (8 lanes x 32-bit accumulators).
- Captures each result vector into a 2-entry ping-pong buffer.
- Streams the vector out one lane per beat over a valid/ready interface, with optional ReLU and requantisation (shift, round, saturate to signed 8-bit).

Parameters:
- LANES, 8, accumulator lanes per result vector.
- ACC_W, 32, width of one accumulator lane.
- Q_W, 8, requantised output width (signed).
- DEPTH, 2, result vectors buffered (fixed at 2; ping-pong).

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rstn_i  in  1  asynchronous active-low reset.
- done_i  in  1  single-cycle pulse from multiplier; matmul_i valid this cycle.
- matmul_i  in  LANES*ACC_W  result vector; lane k = bits [k*ACC_W +: ACC_W], signed.
- quant_en_i  in  1  1 = requantise, 0 = pass raw accumulator.
- relu_i  in  1  1 = clamp negative lanes to 0 before requant.
- shift_i  in  5  arithmetic right-shift amount for requant.
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  downstream accepts beat.
- m_data_o  out  ACC_W  lane value; sign-extended Q_W result when quant enabled.
- m_idx_o  out  3  lane index of current beat.
- m_last_o  out  1  high on lane LANES-1 beat.
- busy_o  out  1  buffer non-empty.
- overflow_o  out  1  sticky; a done_i was dropped.
- clr_ovf_i  in  1  synchronous clear of overflow_o.

Behaviour:
- Reset (async, rstn_i low): m_valid_o=0, m_data_o=0, m_idx_o=0, m_last_o=0, busy_o=0, overflow_o=0. Buffer empty, wr_ptr=rd_ptr=0, count=0, lane idx=0. A reset mid-stream discards all buffered vectors.
- Capture: on a clk edge with done_i=1 and count<2, write matmul_i plus quant_en_i/relu_i/shift_i into entry wr_ptr. Config is latched per vector, so later changes do not affect a buffered vector.
- Latency: m_valid_o is first high on the cycle after the capture edge when the buffer was empty.
- FSM:
  - IDLE (count=0): m_valid_o=0.
  - Capture -> STREAM.
  - STREAM: m_valid_o=1, presenting lane idx of entry rd_ptr.
  - Beat transfers when m_valid_o&&m_ready_i. On transfer, idx++.
  - On transfer at idx=LANES-1: idx->0, rd_ptr toggles, count--. Go to IDLE if count becomes 0, else stay in STREAM on the next vector with no bubble.
- Handshake: while m_valid_o=1 and m_ready_i=0, m_data_o/m_idx_o/m_last_o are held stable. m_valid_o never drops without a transfer.
- Outputs are registered: m_data_o is driven from the lane mux through one output register. The next beat must already be prefetched so back-to-back transfers sustain 1 beat/cycle.
- Simultaneous done_i with the final-lane transfer while count=2: capture succeeds (the slot frees the same cycle) and count stays 2.
- done_i with count=2 and no final-lane transfer: vector dropped, overflow_o<=1, buffer unchanged.
- clr_ovf_i with a drop in the same cycle: the set wins.
- Arithmetic per lane, with x signed ACC_W:
  - relu: if relu=1 and x<0 then x=0.
  - quant_en=0: m_data_o = x.
  - quant_en=1, rounding: if shift>0, y = (x + (1<<(shift-1))) >>> shift; otherwise y = x. The add is done in ACC_W+1 bits, so no wrap.
  - quant_en=1, saturation: saturate y to [-128,127], then sign-extend to ACC_W.
- busy_o = (count!=0).

Decomposition:
- Package matmul_pkg: LANES, ACC_W, Q_W constants; lane_idx_t (3-bit); acc_t (signed ACC_W); q_t (signed Q_W); cfg struct {quant_en, relu, shift}. The multiplier top shares this package.
- Sub-module requant_lane: purely combinational relu/round/shift/saturate for one lane, instantiated once after the lane mux.

Test Plan:
- Single vector, quant off, m_ready_i=1, lanes 1..8: m_valid_o rises 1 cycle after done_i. Beats idx 0..7 are 1..8 on 8 consecutive cycles, m_last_o high only on idx 7, then busy_o=0.
- Quant on, shift=2, relu=0: lanes 100, 1000, -200, -1000 produce 25, 127, -50, -128. With shift=0, lane 100 produces 100.
- relu=1, quant on, shift=0: lanes -5, 7 produce 0, 7. With quant off and relu=1, lane -5 produces 0.
- Backpressure: m_ready_i toggles 1/0 each cycle. Data and idx are held during ready=0, all 8 beats arrive in order, none duplicated or lost.
- Ping-pong: second done_i arrives at lane 3 of the first vector, then a third done_i exactly at the final-lane transfer. All three vectors are streamed back-to-back with no bubble and overflow_o stays 0. A fourth done_i while full with ready=0 sets overflow_o, and clr_ovf_i clears it.
- Reset asserted mid-stream at idx 4: outputs go to 0 immediately. After release, busy_o=0, and a new done_i streams from idx 0.
